wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
Schedules up to N_REQ execution-unit results (ALU0, ALU1, MUL, LSU by default) onto the two writeback slots, inst0 and inst1, that feed the WriteBack stage.
- Grants the two oldest valid results per cycle, ordered by scoreboard id relative to the scoreboard head.
- Registers them, one cycle of latency.
- Suppresses wrong-path results after a redirect until the flush returns.

Parameters:
N_REQ, 4, number of requesting execution units (2..8)
SW, `SCOREBOARD_SIZE_WIDTH, scoreboard id width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  N_REQ  per-unit result valid
req_ready_o  out  N_REQ  per-unit grant; result consumed when valid&ready
req_rd_i  in  5*N_REQ  destination register, unit k at [5k+:5]
req_value_i  in  64*N_REQ  result value
req_pc_i  in  64*N_REQ  instruction pc
req_inst_i  in  32*N_REQ  instruction word
req_sid_i  in  SW*N_REQ  scoreboard id
req_redirect_i  in  N_REQ  result carries a redirect
req_redirect_pc_i  in  64*N_REQ  redirect target
sb_head_i  in  SW  sid of oldest in-flight instruction
flush_i  in  1  registered redirect from WriteBack
inst0_wb_valid_o, inst0_wb_rd_o(5), inst0_wb_value_o(64), inst0_wb_pc_o(64), inst0_wb_inst_o(32), inst0_wb_sid_o(SW), inst0_wb_redirect_o(1), inst0_wb_redirect_pc_o(64)  out  slot0 (older) to WriteBack
inst1_wb_* (same set)  out  slot1 (younger) to WriteBack

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN.
  - inst0/inst1 valid_o=0, redirect_o=0; all other outputs 0.
  - req_ready_o is combinational and therefore 0 while reset is held.
- Age: age_k = (req_sid_k - sb_head_i) mod 2^SW, unsigned SW-bit subtract with wrap. Smaller age is older. Valid sids are unique; on an equal age the lower index wins.
- RUN state:
  - g0 = oldest valid requester; g1 = next oldest valid requester, excluding g0.
  - req_ready_o[g0]=1 whenever any request is valid.
  - req_ready_o[g1]=1 only if a second request is valid and req_redirect_i[g0]=0.
  - All other ready_o are 0. Ungranted units hold valid and payload stable.
- Output register: on the next posedge, slot0 <= payload of g0, slot1 <= payload of g1, valid as granted. Latency is exactly 1 cycle. Slot0 is always older than slot1. Slot1 is never valid without slot0.
- Redirect squash:
  - If g0 or g1 carries a redirect, after that edge state -> WAIT_FLUSH.
  - In WAIT_FLUSH: ready_o=0 for all units; output valids are 0 from the following cycle.
- WAIT_FLUSH -> RUN when flush_i=1.
- flush_i=1 in the cycle of any state:
  - ready_o=1 for every valid requester (drain; the results are discarded).
  - Output valids register 0.
  - Next state is RUN.
- flush_i has priority over any grant in the same cycle.
- Zero or one valid request: unused slot registers valid=0; payload is don't-care but holds its previous value.
- Reset asserted mid-operation clears state and output valids immediately (asynchronous). Pending requests are not granted until reset releases.

Optional Feature:
WB_ARB_PERF_CNT_EN:
- Defined: adds outputs perf_conflict_cnt_o[31:0] and perf_squash_cnt_o[31:0], both reset to 0 and wrapping.
  - perf_conflict_cnt_o increments each cycle in RUN with flush_i=0 and more than two valid requests.
  - perf_squash_cnt_o increments each cycle in WAIT_FLUSH, and on each flush cycle that drains at least one valid request.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package kiwi_wb_pkg holds:
  - SCOREBOARD_SIZE_WIDTH
  - the default N_REQ
  - the wb_arb_state_e enum {RUN, WAIT_FLUSH}
  - the wb_payload_t struct {rd, value, pc, inst, sid, redirect, redirect_pc}
- Sub-module wb_age_select: combinational. Inputs are the valid vector, the sid vector and sb_head. Outputs are g0/g1 one-hot plus has0/has1. It is reusable by a future issue-side scheduler.

Test Plan:
1. sb_head=6, SW=4. Units 0..3 valid with sids 9, 7, 15, 8 -> ready_o=0b0010 | 0b1000. Next cycle inst0 sid=7, inst1 sid=8. Units 0 and 2 hold, then are granted the following cycle with inst0 sid=9, inst1 sid=15.
2. Wrap: sb_head=14, SW=4. Valid sids 1 (unit 0) and 15 (unit 1) -> inst0 sid=15, inst1 sid=1.
3. Unit 1 is oldest with redirect=1 (pc 0x8000_0100) and unit 0 is next oldest -> only unit 1 ready. inst0 redirect_pc=0x8000_0100, inst1 valid=0. Then ready_o=0 and valids 0 for each WAIT_FLUSH cycle until flush_i.
4. In WAIT_FLUSH with three units valid, pulse flush_i -> all three ready_o=1 that cycle, output valids 0 next cycle, state RUN. Fresh requests the cycle after are granted normally.
5. Single valid request (unit 3, sid 2) -> inst0 valid with sid 2, inst1 valid=0. No requests -> both valids 0.
6. Drop rst_n asynchronously while outputs are valid in WAIT_FLUSH -> valids 0 before the next clock edge. After release, state is RUN and grants resume. With WB_ARB_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/kiwi_wb_pkg.sv
// Shared writeback-arbiter types: scoreboard id width, default requester count,
// arbiter state encoding and the per-result writeback payload.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif

package kiwi_wb_pkg;

    localparam int unsigned SCOREBOARD_SIZE_WIDTH = `SCOREBOARD_SIZE_WIDTH;
    localparam int unsigned WB_N_REQ              = 4;
    localparam int unsigned WB_RD_W               = 5;
    localparam int unsigned WB_XLEN               = 64;
    localparam int unsigned WB_ILEN               = 32;

    typedef enum logic {
        RUN        = 1'b0,
        WAIT_FLUSH = 1'b1
    } wb_arb_state_e;

    typedef struct packed {
        logic [WB_RD_W-1:0]               rd;
        logic [WB_XLEN-1:0]               value;
        logic [WB_XLEN-1:0]               pc;
        logic [WB_ILEN-1:0]               inst;
        logic [SCOREBOARD_SIZE_WIDTH-1:0] sid;
        logic                             redirect;
        logic [WB_XLEN-1:0]               redirect_pc;
    } wb_payload_t;

endpackage

// File: rtl/wb_age_select.sv
// Picks the oldest and second-oldest valid requesters by scoreboard age
// (sid - head, modulo 2^SW). Ties resolve to the lower index.
module wb_age_select
    import kiwi_wb_pkg::*;
#(
    parameter int unsigned N_REQ = WB_N_REQ,
    parameter int unsigned SW    = SCOREBOARD_SIZE_WIDTH
) (
    input  logic [N_REQ-1:0]    valid,
    input  logic [SW*N_REQ-1:0] sid,
    input  logic [SW-1:0]       sb_head,
    output logic [N_REQ-1:0]    g0_oh_c,
    output logic [N_REQ-1:0]    g1_oh_c,
    output logic                has0_c,
    output logic                has1_c
);

    logic [SW-1:0] age [N_REQ];

    // Age of each requester relative to the scoreboard head, wrapping.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            age[k] = sid[k*SW +: SW] - sb_head;
        end
    end

    // Oldest valid requester; strict compare keeps the lower index on ties.
    always_comb begin
        logic [N_REQ-1:0] oh;
        logic             found;
        logic [SW-1:0]    best;
        oh    = '0;
        found = 1'b0;
        best  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (valid[k] && (!found || (age[k] < best))) begin
                oh    = '0;
                oh[k] = 1'b1;
                found = 1'b1;
                best  = age[k];
            end
        end
        g0_oh_c = oh;
        has0_c  = found;
    end

    // Next-oldest valid requester with the first pick masked out.
    always_comb begin
        logic [N_REQ-1:0] oh;
        logic             found;
        logic [SW-1:0]    best;
        oh    = '0;
        found = 1'b0;
        best  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (valid[k] && !g0_oh_c[k] && (!found || (age[k] < best))) begin
                oh    = '0;
                oh[k] = 1'b1;
                found = 1'b1;
                best  = age[k];
            end
        end
        g1_oh_c = oh;
        has1_c  = found;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Schedules up to N_REQ execution-unit results onto the two writeback slots,
// oldest first, with one cycle of latency; squashes wrong-path results after a
// redirect until the flush comes back.
// Optional macro WB_ARB_PERF_CNT_EN adds conflict/squash performance counters.
module wb_port_arbiter
    import kiwi_wb_pkg::*;
#(
    parameter int unsigned N_REQ = WB_N_REQ,
    parameter int unsigned SW    = SCOREBOARD_SIZE_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic [5*N_REQ-1:0]   req_rd_i,
    input  logic [64*N_REQ-1:0]  req_value_i,
    input  logic [64*N_REQ-1:0]  req_pc_i,
    input  logic [32*N_REQ-1:0]  req_inst_i,
    input  logic [SW*N_REQ-1:0]  req_sid_i,
    input  logic [N_REQ-1:0]     req_redirect_i,
    input  logic [64*N_REQ-1:0]  req_redirect_pc_i,
    input  logic [SW-1:0]        sb_head_i,
    input  logic                 flush_i,
    output logic                 inst0_wb_valid_o,
    output logic [4:0]           inst0_wb_rd_o,
    output logic [63:0]          inst0_wb_value_o,
    output logic [63:0]          inst0_wb_pc_o,
    output logic [31:0]          inst0_wb_inst_o,
    output logic [SW-1:0]        inst0_wb_sid_o,
    output logic                 inst0_wb_redirect_o,
    output logic [63:0]          inst0_wb_redirect_pc_o,
    output logic                 inst1_wb_valid_o,
    output logic [4:0]           inst1_wb_rd_o,
    output logic [63:0]          inst1_wb_value_o,
    output logic [63:0]          inst1_wb_pc_o,
    output logic [31:0]          inst1_wb_inst_o,
    output logic [SW-1:0]        inst1_wb_sid_o,
    output logic                 inst1_wb_redirect_o,
    output logic [63:0]          inst1_wb_redirect_pc_o
`ifdef WB_ARB_PERF_CNT_EN
    ,
    output logic [31:0]          perf_conflict_cnt_o,
    output logic [31:0]          perf_squash_cnt_o
`endif
);

    wb_arb_state_e    state_q, state_next;
    wb_payload_t      unit_pay [N_REQ];
    wb_payload_t      pay0_c, pay1_c;
    wb_payload_t      slot0_q, slot1_q;
    logic             valid0_q, valid1_q;
    logic [N_REQ-1:0] g0_oh_c, g1_oh_c, ready_c;
    logic             has0_c, has1_c, take0_c, take1_c;

    wb_age_select #(.N_REQ(N_REQ), .SW(SW)) u_age_select (
        .valid   (req_valid_i),
        .sid     (req_sid_i),
        .sb_head (sb_head_i),
        .g0_oh_c (g0_oh_c),
        .g1_oh_c (g1_oh_c),
        .has0_c  (has0_c),
        .has1_c  (has1_c)
    );

    // Unpack the flat per-unit buses into payload structs.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            unit_pay[k].rd          = req_rd_i[k*5 +: 5];
            unit_pay[k].value       = req_value_i[k*64 +: 64];
            unit_pay[k].pc          = req_pc_i[k*64 +: 64];
            unit_pay[k].inst        = req_inst_i[k*32 +: 32];
            unit_pay[k].sid         = SCOREBOARD_SIZE_WIDTH'(req_sid_i[k*SW +: SW]);
            unit_pay[k].redirect    = req_redirect_i[k];
            unit_pay[k].redirect_pc = req_redirect_pc_i[k*64 +: 64];
        end
    end

    // One-hot payload mux for the two grants.
    always_comb begin
        pay0_c = '0;
        pay1_c = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (g0_oh_c[k]) pay0_c = unit_pay[k];
            if (g1_oh_c[k]) pay1_c = unit_pay[k];
        end
    end

    // Next state and grants; a flush drains every valid requester and wins.
    always_comb begin
        state_next = state_q;
        ready_c    = '0;
        take0_c    = 1'b0;
        take1_c    = 1'b0;
        if (flush_i) begin
            ready_c    = req_valid_i;
            state_next = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (has0_c) begin
                        take0_c = 1'b1;
                        ready_c = ready_c | g0_oh_c;
                    end
                    if (has1_c && !pay0_c.redirect) begin
                        take1_c = 1'b1;
                        ready_c = ready_c | g1_oh_c;
                    end
                    if ((take0_c && pay0_c.redirect) || (take1_c && pay1_c.redirect)) begin
                        state_next = WAIT_FLUSH;
                    end
                end
                WAIT_FLUSH: begin
                end
                default: state_next = RUN;
            endcase
        end
    end

    // Ready is held low while reset is asserted.
    assign req_ready_o = ready_c & {N_REQ{rst_n}};

    // State and writeback slot registers; unused slots keep their payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            slot0_q  <= '0;
            slot1_q  <= '0;
        end else begin
            state_q  <= state_next;
            valid0_q <= take0_c;
            valid1_q <= take1_c;
            if (take0_c) slot0_q <= pay0_c;
            if (take1_c) slot1_q <= pay1_c;
        end
    end

    assign inst0_wb_valid_o       = valid0_q;
    assign inst0_wb_rd_o          = slot0_q.rd;
    assign inst0_wb_value_o       = slot0_q.value;
    assign inst0_wb_pc_o          = slot0_q.pc;
    assign inst0_wb_inst_o        = slot0_q.inst;
    assign inst0_wb_sid_o         = SW'(slot0_q.sid);
    assign inst0_wb_redirect_o    = slot0_q.redirect;
    assign inst0_wb_redirect_pc_o = slot0_q.redirect_pc;

    assign inst1_wb_valid_o       = valid1_q;
    assign inst1_wb_rd_o          = slot1_q.rd;
    assign inst1_wb_value_o       = slot1_q.value;
    assign inst1_wb_pc_o          = slot1_q.pc;
    assign inst1_wb_inst_o        = slot1_q.inst;
    assign inst1_wb_sid_o         = SW'(slot1_q.sid);
    assign inst1_wb_redirect_o    = slot1_q.redirect;
    assign inst1_wb_redirect_pc_o = slot1_q.redirect_pc;

`ifdef WB_ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt_q, squash_cnt_q;

    // Count cycles with more than two results competing, and squash cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
            squash_cnt_q   <= '0;
        end else begin
            if ((state_q == RUN) && !flush_i && ($countones(req_valid_i) > 2)) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
            if ((state_q == WAIT_FLUSH) || (flush_i && (|req_valid_i))) begin
                squash_cnt_q <= squash_cnt_q + 32'd1;
            end
        end
    end

    assign perf_conflict_cnt_o = conflict_cnt_q;
    assign perf_squash_cnt_o   = squash_cnt_q;
`endif

endmodule
